alu_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer that shares one ALU instance between two requesters. It captures the granted requester's opcode and operands, issues a one-cycle start to the ALU control unit, and waits for its done. It then returns the result to the owning requester. A watchdog aborts any ALU operation that exceeds TIMEOUT cycles and flags it as an error.

---
 rtl/alu_arbiter.sv | 161 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one ALU between two requesters: captures the
// granted request, pulses alu_start, waits for alu_done or a watchdog timeout.
module alu_arbiter #(
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic           clk,
    input  logic           rst_b,
    input  logic           req0,
    input  logic           req1,
    input  logic [1:0]     op0,
    input  logic [1:0]     op1,
    input  logic [W-1:0]   a0,
    input  logic [W-1:0]   a1,
    input  logic [W-1:0]   b0,
    input  logic [W-1:0]   b1,
    output logic           gnt0,
    output logic           gnt1,
    output logic           done0,
    output logic           done1,
    output logic [2*W-1:0] res0,
    output logic [2*W-1:0] res1,
    output logic           err0,
    output logic           err1,
    output logic           busy,
    output logic           alu_start,
    output logic [1:0]     alu_op,
    output logic [W-1:0]   alu_x,
    output logic [W-1:0]   alu_y,
    output logic           alu_abort,
    input  logic           alu_done,
    input  logic [2*W-1:0] alu_result
);

    localparam int unsigned    CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  LAST_WAIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } state_t;

    state_t            state_q;
    logic              owner_q;
    logic              rr_last_q;
    logic [CW-1:0]     wd_cnt_q;
    logic              gnt0_q, gnt1_q;
    logic              done0_q, done1_q;
    logic [2*W-1:0]    res0_q, res1_q;
    logic              err0_q, err1_q;
    logic              busy_q;
    logic              start_q;
    logic              abort_q;
    logic [1:0]        op_q;
    logic [W-1:0]      x_q, y_q;

    logic              pick_d;
    logic              finish_d;

    // On a tie the port that was not served last wins.
    always_comb begin
        pick_d = 1'b0;
        if (req0 && req1) begin
            pick_d = ~rr_last_q;
        end else if (!req0) begin
            pick_d = 1'b1;
        end
    end

    // alu_done on the last watchdog cycle still counts as a normal completion.
    assign finish_d = alu_done || (wd_cnt_q == LAST_WAIT);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            wd_cnt_q  <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            res0_q    <= '0;
            res1_q    <= '0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
            op_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        owner_q <= pick_d;
                        op_q    <= pick_d ? op1 : op0;
                        x_q     <= pick_d ? a1 : a0;
                        y_q     <= pick_d ? b1 : b0;
                        gnt0_q  <= ~pick_d;
                        gnt1_q  <= pick_d;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    wd_cnt_q <= '0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (finish_d) begin
                        if (owner_q) begin
                            res1_q  <= alu_done ? alu_result : '0;
                            err1_q  <= ~alu_done;
                            done1_q <= 1'b1;
                        end else begin
                            res0_q  <= alu_done ? alu_result : '0;
                            err0_q  <= ~alu_done;
                            done0_q <= 1'b1;
                        end
                        abort_q   <= ~alu_done;
                        rr_last_q <= owner_q;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign res0      = res0_q;
    assign res1      = res1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign busy      = busy_q;
    assign alu_start = start_q;
    assign alu_op    = op_q;
    assign alu_x     = x_q;
    assign alu_y     = y_q;
    assign alu_abort = abort_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal timing/values, then randomized traffic.
module tb_alu_arbiter;

    localparam int unsigned W       = 8;
    localparam int unsigned TIMEOUT = 32;

    localparam int S_GNT0  = 0;
    localparam int S_GNT1  = 1;
    localparam int S_DONE0 = 2;
    localparam int S_DONE1 = 3;
    localparam int S_ABORT = 4;
    localparam int S_GNT   = 5;

    logic             clk;
    logic             rst_b;
    logic [1:0]       req;
    logic [1:0]       op [2];
    logic [W-1:0]     a  [2];
    logic [W-1:0]     b  [2];
    logic             gnt0, gnt1, done0, done1, err0, err1, busy;
    logic [2*W-1:0]   res0, res1;
    logic             alu_start, alu_abort, alu_done;
    logic [1:0]       alu_op;
    logic [W-1:0]     alu_x, alu_y;
    logic [2*W-1:0]   alu_result;

    int n_err;
    int n_checks;

    // ALU responder controls
    int               next_lat;
    logic [2*W-1:0]   next_res;
    logic             rand_lat;
    logic             noise;
    int               cur_lat, wcnt;
    logic [2*W-1:0]   cur_res;
    logic             armed;

    // reference model: owner (-1 = none), age (0 = grant cycle, k = k-th WAIT cycle)
    int               m_own, m_age, m_rr;
    logic [1:0]       e_gnt, e_done, e_err;
    logic [2*W-1:0]   e_res [2];
    logic             e_busy, e_start, e_abort;
    logic [1:0]       e_op;
    logic [W-1:0]     e_x, e_y;

    alu_arbiter #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .req0       (req[0]),
        .req1       (req[1]),
        .op0        (op[0]),
        .op1        (op[1]),
        .a0         (a[0]),
        .a1         (a[1]),
        .b0         (b[0]),
        .b1         (b[1]),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .done0      (done0),
        .done1      (done1),
        .res0       (res0),
        .res1       (res1),
        .err0       (err0),
        .err1       (err1),
        .busy       (busy),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_abort  (alu_abort),
        .alu_done   (alu_done),
        .alu_result (alu_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] dut_vec();
        return 64'({gnt1, gnt0, done1, done0, res1, res0, err1, err0,
                    busy, alu_start, alu_op, alu_x, alu_y, alu_abort});
    endfunction

    function automatic logic [63:0] exp_vec();
        return 64'({e_gnt[1], e_gnt[0], e_done[1], e_done[0], e_res[1], e_res[0],
                    e_err[1], e_err[0], e_busy, e_start, e_op, e_x, e_y, e_abort});
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            S_GNT0:  return gnt0;
            S_GNT1:  return gnt1;
            S_DONE0: return done0;
            S_DONE1: return done1;
            S_ABORT: return alu_abort;
            S_GNT:   return gnt0 | gnt1;
            default: return done0 | done1;
        endcase
    endfunction

    task automatic model_reset();
        m_own    = -1;
        m_age    = 0;
        m_rr     = 1;
        e_gnt    = '0;
        e_done   = '0;
        e_err    = '0;
        e_res[0] = '0;
        e_res[1] = '0;
        e_busy   = 1'b0;
        e_start  = 1'b0;
        e_abort  = 1'b0;
        e_op     = '0;
        e_x      = '0;
        e_y      = '0;
    endtask

    // Advance the model by one clock using the inputs the DUT is about to sample.
    task automatic model_step();
        int p;
        e_gnt   = '0;
        e_done  = '0;
        e_start = 1'b0;
        e_abort = 1'b0;
        if (m_own < 0) begin
            if (req != 2'b00) begin
                if (req == 2'b11) p = (m_rr == 1) ? 0 : 1;
                else              p = req[0] ? 0 : 1;
                m_own    = p;
                m_age    = 0;
                e_gnt[p] = 1'b1;
                e_start  = 1'b1;
                e_busy   = 1'b1;
                e_op     = op[p];
                e_x      = a[p];
                e_y      = b[p];
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (alu_done || m_age == int'(TIMEOUT)) begin
            e_res[m_own]  = alu_done ? alu_result : '0;
            e_err[m_own]  = !alu_done;
            e_done[m_own] = 1'b1;
            e_abort       = !alu_done;
            e_busy        = 1'b0;
            m_rr          = m_own;
            m_own         = -1;
        end else begin
            m_age = m_age + 1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input int sel, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sig(sel) && n < 200);
    endtask

    task automatic set_req(input int p, input logic v, input logic [1:0] o,
                           input logic [W-1:0] x, input logic [W-1:0] y);
        req[p] = v;
        op[p]  = o;
        a[p]   = x;
        b[p]   = y;
    endtask

    task automatic rand_ops(input int p);
        op[p] = 2'($urandom);
        a[p]  = W'($urandom);
        b[p]  = W'($urandom);
    endtask

    // ALU stand-in: answers on the chosen WAIT cycle, otherwise may toggle alu_done randomly.
    always begin
        @(posedge clk);
        #1;
        alu_done = 1'b0;
        if (noise && !armed) begin
            alu_done   = ($urandom_range(0, 3) == 0);
            alu_result = 16'($urandom);
        end
        if (!rst_b) begin
            armed = 1'b0;
        end else if (alu_start) begin
            armed = 1'b1;
            wcnt  = 0;
            if (rand_lat) begin
                case ($urandom_range(0, 9))
                    0:       cur_lat = 0;
                    1:       cur_lat = int'(TIMEOUT);
                    2:       cur_lat = int'(TIMEOUT) - 1;
                    default: cur_lat = int'($urandom_range(1, 5));
                endcase
                cur_res = 16'($urandom);
            end else begin
                cur_lat = next_lat;
                cur_res = next_res;
            end
        end else if (armed) begin
            wcnt++;
            if (wcnt == cur_lat) begin
                alu_done   = 1'b1;
                alu_result = cur_res;
                armed      = 1'b0;
            end else begin
                alu_result = 16'($urandom);
                if (wcnt >= int'(TIMEOUT)) armed = 1'b0;
            end
        end
    end

    initial begin
        int n;
        int port;
        n_err      = 0;
        n_checks   = 0;
        rst_b      = 1'b0;
        req        = 2'b00;
        for (int p = 0; p < 2; p++) set_req(p, 1'b0, 2'd0, '0, '0);
        next_lat   = 1;
        next_res   = '0;
        rand_lat   = 1'b0;
        noise      = 1'b1;
        armed      = 1'b0;
        wcnt       = 0;
        cur_lat    = 0;
        cur_res    = '0;
        alu_done   = 1'b0;
        alu_result = '0;
        model_reset();

        fork
            forever begin
                @(negedge clk);
                if (!rst_b) model_reset();
                n_checks++;
                if (dut_vec() !== exp_vec()) begin
                    n_err++;
                    $display("FAIL cycle_outputs: got %h expected %h (t=%0t)",
                             dut_vec(), exp_vec(), $time);
                end
                if (rst_b) model_step();
            end
        join_none

        repeat (3) tick();
        check("reset_state", dut_vec(), 64'd0);
        rst_b = 1'b1;
        tick();

        // single request, ALU answers on the 10th WAIT cycle
        next_lat = 10;
        next_res = 16'h0023;
        set_req(0, 1'b1, 2'd2, 8'd5, 8'd7);
        wait_for(S_GNT0, n);
        check("t1_gnt_latency", 64'(n), 64'd1);
        check("t1_start", 64'(alu_start), 64'd1);
        check("t1_x", 64'(alu_x), 64'd5);
        check("t1_y", 64'(alu_y), 64'd7);
        check("t1_op", 64'(alu_op), 64'd2);
        req[0] = 1'b0;
        wait_for(S_DONE0, n);
        check("t1_done_latency", 64'(n), 64'd11);
        check("t1_res0", 64'(res0), 64'h23);
        check("t1_err0", 64'(err0), 64'd0);
        check("t1_busy_low", 64'(busy), 64'd0);

        // simultaneous held requests from reset
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        next_lat = 1;
        next_res = 16'h00a5;
        set_req(0, 1'b1, 2'd1, 8'd3, 8'd4);
        set_req(1, 1'b1, 2'd3, 8'd9, 8'd8);
        for (int i = 0; i < 4; i++) begin
            wait_for(S_GNT, n);
            port = gnt1 ? 1 : 0;
            check("t2_grant_order", 64'(port), 64'(i % 2));
            check("t2_grant_gap", 64'(n), (i == 0) ? 64'd1 : 64'd3);
        end
        req = 2'b00;
        repeat (4) tick();

        // single persistent requester on port 1
        next_res = 16'h5a5a;
        set_req(1, 1'b1, 2'd0, 8'd17, 8'd2);
        wait_for(S_GNT1, n);
        check("t3_first_gnt", 64'(n), 64'd1);
        wait_for(S_DONE1, n);
        check("t3_done_latency", 64'(n), 64'd2);
        wait_for(S_GNT1, n);
        check("t3_done_to_gnt", 64'(n), 64'd1);
        req[1] = 1'b0;
        wait_for(S_DONE1, n);
        check("t3_res1", 64'(res1), 64'h5a5a);
        repeat (2) tick();

        // watchdog timeout, then a normal transaction
        next_lat = 0;
        set_req(0, 1'b1, 2'd1, 8'd9, 8'd3);
        wait_for(S_GNT0, n);
        req[0] = 1'b0;
        wait_for(S_ABORT, n);
        check("t4_abort_latency", 64'(n), 64'(TIMEOUT + 1));
        check("t4_done0", 64'(done0), 64'd1);
        check("t4_res0", 64'(res0), 64'd0);
        check("t4_err0", 64'(err0), 64'd1);
        check("t4_busy", 64'(busy), 64'd0);
        next_lat = 3;
        next_res = 16'h1234;
        set_req(0, 1'b1, 2'd2, 8'd1, 8'd1);
        wait_for(S_GNT0, n);
        check("t4_regrant", 64'(n), 64'd1);
        req[0] = 1'b0;
        wait_for(S_DONE0, n);
        check("t4_recover_latency", 64'(n), 64'd4);
        check("t4_recover_res0", 64'(res0), 64'h1234);
        check("t4_recover_err0", 64'(err0), 64'd0);

        // alu_done on exactly the last allowed WAIT cycle
        next_lat = int'(TIMEOUT);
        next_res = 16'hbeef;
        set_req(0, 1'b1, 2'd3, 8'd200, 8'd100);
        wait_for(S_GNT0, n);
        req[0] = 1'b0;
        wait_for(S_DONE0, n);
        check("t5_done_latency", 64'(n), 64'(TIMEOUT + 1));
        check("t5_err0", 64'(err0), 64'd0);
        check("t5_res0", 64'(res0), 64'hbeef);
        check("t5_no_abort", 64'(alu_abort), 64'd0);

        // reset in the middle of WAIT
        next_lat = 0;
        set_req(0, 1'b1, 2'd1, 8'd44, 8'd55);
        wait_for(S_GNT0, n);
        req[0] = 1'b0;
        repeat (5) tick();
        rst_b = 1'b0;
        #1;
        check("t6_async_clear", dut_vec(), 64'd0);
        tick();
        tick();
        rst_b = 1'b1;
        next_lat = 2;
        next_res = 16'h0f0f;
        set_req(0, 1'b1, 2'd0, 8'd6, 8'd6);
        set_req(1, 1'b1, 2'd0, 8'd7, 8'd7);
        wait_for(S_GNT, n);
        check("t6_first_after_reset", 64'(n), 64'd1);
        check("t6_port0_first", 64'({gnt1, gnt0}), 64'd1);
        req = 2'b00;
        wait_for(S_DONE0, n);
        check("t6_done_latency", 64'(n), 64'd3);

        // randomized traffic
        rand_lat = 1'b1;
        repeat (4000) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (sig(p)) begin
                    req[p] = 1'($urandom_range(0, 1));
                    rand_ops(p);
                end else if (!req[p] && $urandom_range(0, 2) == 0) begin
                    req[p] = 1'b1;
                    rand_ops(p);
                end
            end
        end
        req = 2'b00;
        n = 0;
        while (busy && n < 80) begin
            tick();
            n++;
        end
        check("drain_idle", 64'(busy), 64'd0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
